// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Bus-mapped scan controller for a multiplexed common-anode 7-segment display.
// Two word registers sit on the 32-bit peripheral bus:
//   BASE   : VALUE, nibble i is the hex digit shown on digit i (0 = rightmost)
//   BASE+1 : CTRL, bit 0 display on, bit 1 leading-zero blank,
//            bits 15:8 decimal-point mask (bit 8+i lights the dp of digit i)
// Each digit owns a slot of 2^PERIODBITS clocks. The first DEAD clocks of
// every slot are blanked to avoid ghosting between digits.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   enable   bus cycle strobe
//   rw       1 = write, 0 = read
//   addr     bus word address
//   d_in     write data
//   d_out    registered read data (one cycle latency)
//   seg      active-low segments, seg[7] = dp, seg[6:0] = g..a
//   an       active-low digit enables
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter logic [31:0] BASE       = 32'h0,
    parameter int          NDIGITS    = 4,
    parameter int          PERIODBITS = 16,
    parameter int          DEAD       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               rw,
    input  logic [31:0]        addr,
    input  logic [31:0]        d_in,
    output logic [31:0]        d_out,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an
);

    localparam int                    IDXW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PERIODBITS-1:0] DEAD_LAST  = PERIODBITS'(DEAD - 1);
    localparam logic [IDXW-1:0]       LAST_DIGIT = IDXW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t                state;
    logic [31:0]           value_reg;
    logic                  disp_on;
    logic                  lz_blank_en;
    logic [7:0]            dp_mask;
    logic [PERIODBITS-1:0] prescaler;
    logic [IDXW-1:0]       idx;

    logic                  hit_value;
    logic                  hit_ctrl;
    logic [31:0]           ctrl_word;
    logic [3:0]            nibble;
    logic                  upper_zero;
    logic                  blank_digit;
    logic [NDIGITS-1:0]    an_sel;
    logic                  slot_tick;

    assign hit_value = (addr == BASE);
    assign hit_ctrl  = (addr == (BASE + 32'd1));
    assign ctrl_word = {16'h0000, dp_mask, 6'b000000, lz_blank_en, disp_on};
    assign slot_tick = (prescaler == {PERIODBITS{1'b1}});

    // Hex digit to active-low {g..a} segment pattern.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'h7F;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Bus side: register writes and the registered read port. Unmapped
    // addresses ignore writes and read back as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_reg   <= 32'h0;
            disp_on     <= 1'b0;
            lz_blank_en <= 1'b0;
            dp_mask     <= 8'h00;
            d_out       <= 32'h0;
        end else if (enable) begin
            if (rw) begin
                if (hit_value) begin
                    value_reg <= d_in;
                end
                if (hit_ctrl) begin
                    disp_on     <= d_in[0];
                    lz_blank_en <= d_in[1];
                    dp_mask     <= d_in[15:8];
                end
            end else begin
                if (hit_value) begin
                    d_out <= value_reg;
                end else if (hit_ctrl) begin
                    d_out <= ctrl_word;
                end else begin
                    d_out <= 32'h0;
                end
            end
        end
    end

    // Digit currently selected by the scan index, the one-cold anode pattern
    // for it, and whether it counts as a leading zero (it and every more
    // significant digit are zero).
    always_comb begin
        nibble     = value_reg[{idx, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            if ((k >= int'(idx)) && (value_reg[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        an_sel      = '1;
        an_sel[idx] = 1'b0;
        blank_digit = lz_blank_en && (idx != '0) && upper_zero;
    end

    // Scan FSM. seg/an are registered and only change at the BLANK->SHOW
    // latch, at the slot tick, or when the display is switched off, so bus
    // writes during SHOW never disturb the glyph being displayed. The
    // switch-off check looks at the CTRL register itself, so the display
    // goes dark on the edge after the CTRL[0]=0 write has landed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_OFF;
            prescaler <= '0;
            idx       <= '0;
            seg       <= 8'hFF;
            an        <= '1;
        end else if (!disp_on) begin
            state     <= S_OFF;
            prescaler <= '0;
            idx       <= '0;
            seg       <= 8'hFF;
            an        <= '1;
        end else begin
            case (state)
                S_OFF: begin
                    state     <= S_BLANK;
                    prescaler <= '0;
                    idx       <= '0;
                end
                S_BLANK: begin
                    prescaler <= prescaler + 1'b1;
                    if (prescaler == DEAD_LAST) begin
                        state <= S_SHOW;
                        seg   <= {~dp_mask[idx], glyph(nibble)};
                        an    <= blank_digit ? {NDIGITS{1'b1}} : an_sel;
                    end
                end
                S_SHOW: begin
                    prescaler <= prescaler + 1'b1;
                    if (slot_tick) begin
                        state <= S_BLANK;
                        seg   <= 8'hFF;
                        an    <= '1;
                        idx   <= (idx == LAST_DIGIT) ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    state     <= S_OFF;
                    prescaler <= '0;
                    idx       <= '0;
                    seg       <= 8'hFF;
                    an        <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Self-checking bench for seg7_scan_ctrl with 4 digits, a 16-cycle slot and a
// 2-cycle dead time. Expected digit showings ({an, seg}) are queued when the
// stimulus programs the display and are popped by a monitor each time a digit
// lights up; the monitor also measures show and blank run lengths.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam logic [31:0] BASE   = 32'h0;
    localparam int          ND     = 4;
    localparam int          PB     = 4;
    localparam int          DEAD   = 2;
    localparam int          SLOT   = 2 ** PB;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          rw = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   d_in = 32'h0;
    logic [31:0]   d_out;
    logic [7:0]    seg;
    logic [ND-1:0] an;

    int errors = 0;
    int checks = 0;

    logic [11:0] disp_q[$];
    logic [31:0] rd_q[$];

    logic        len_chk  = 1'b0;
    logic        had_show = 1'b0;
    logic        last_low = 1'b0;
    int          run_len  = 0;
    logic [11:0] exp_disp;

    seg7_scan_ctrl #(
        .BASE(BASE),
        .NDIGITS(ND),
        .PERIODBITS(PB),
        .DEAD(DEAD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .rw(rw),
        .addr(addr),
        .d_in(d_in),
        .d_out(d_out),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Expected {an, seg} for a digit value shown at a position.
    function automatic logic [11:0] showOf(input int pos, input logic [3:0] val, input logic dp);
        logic [ND-1:0] a;
        a      = '1;
        a[pos] = 1'b0;
        return {a, ~dp, GLYPH[val]};
    endfunction

    // Bus write; called on a negedge, returns on the negedge after the edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1;
        rw     = 1'b1;
        addr   = a;
        d_in   = d;
        @(negedge clk);
        enable = 1'b0;
        rw     = 1'b0;
    endtask

    // Bus read; expected data is queued at the strobe, compared one cycle on.
    task automatic busRead(input string tag, input logic [31:0] a, input logic [31:0] expv);
        enable = 1'b1;
        rw     = 1'b0;
        addr   = a;
        rd_q.push_back(expv);
        @(negedge clk);
        enable = 1'b0;
        checkOutput(tag, d_out, rd_q.pop_front());
    endtask

    // Counts blank cycles from now until a digit lights, bounded.
    task automatic waitShowStart(input string tag, input int expCycles);
        int n;
        n = 0;
        while (an == '1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput(tag, n, expCycles);
    endtask

    // Waits for every queued showing to be observed, bounded.
    task automatic waitDrain(input string tag, input int limit);
        int n;
        n = 0;
        while (disp_q.size() != 0 && n < limit) begin
            n++;
            @(negedge clk);
        end
        checkOutput(tag, disp_q.size(), 0);
    endtask

    // Display monitor: pops one expectation per lit digit and checks run lengths.
    always @(negedge clk) begin
        if (an != '1) begin
            if (!last_low) begin
                if (len_chk && had_show) begin
                    checkOutput("blank_len", run_len, DEAD);
                end
                if (disp_q.size() == 0) begin
                    checkOutput("spurious_show", {20'h0, an, seg}, 32'hFFF);
                end else begin
                    exp_disp = disp_q.pop_front();
                    checkOutput("show", {20'h0, an, seg}, {20'h0, exp_disp});
                end
                run_len = 0;
            end
            run_len++;
            last_low = 1'b1;
        end else begin
            if (last_low) begin
                if (len_chk) begin
                    checkOutput("show_len", run_len, SLOT - DEAD);
                end
                had_show = len_chk;
                run_len  = 0;
            end
            run_len++;
            last_low = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'hFF);
        checkOutput("rst_dout", d_out, 32'h0);
        reset_n = 1'b1;
        busRead("rst_value", BASE, 32'h0);
        busRead("rst_ctrl", BASE + 1, 32'h0);

        // Normal scan of 1234: two full rounds plus digits 0..2 of a third
        applyStimulus(BASE, 32'h1234);
        for (int r = 0; r < 3; r++) begin
            disp_q.push_back(showOf(0, 4'h4, 1'b0));
            disp_q.push_back(showOf(1, 4'h3, 1'b0));
            disp_q.push_back(showOf(2, 4'h2, 1'b0));
            if (r < 2) disp_q.push_back(showOf(3, 4'h1, 1'b0));
        end
        len_chk = 1'b1;
        applyStimulus(BASE + 1, 32'h1);
        waitShowStart("start_delay", 3);
        busRead("value_rb", BASE, 32'h1234);
        busRead("ctrl_rb", BASE + 1, 32'h1);
        waitDrain("drain_scan", 400);

        // Switch off while digit 2 is lit, then restart from digit 0
        checkOutput("stop_digit", 32'(an), 32'hB);
        len_chk = 1'b0;
        applyStimulus(BASE + 1, 32'h0);
        @(negedge clk);
        checkOutput("off_an", 32'(an), 32'hF);
        checkOutput("off_seg", 32'(seg), 32'hFF);
        disp_q.push_back(showOf(0, 4'h4, 1'b0));
        applyStimulus(BASE + 1, 32'h1);
        waitShowStart("restart_delay", 3);
        len_chk = 1'b1;

        // VALUE rewrite mid-show of digit 1 only takes effect from digit 2
        disp_q.push_back(showOf(1, 4'h3, 1'b0));
        disp_q.push_back(showOf(2, 4'hF, 1'b0));
        disp_q.push_back(showOf(3, 4'hF, 1'b0));
        begin
            int n;
            n = 0;
            while (an != 4'hD && n < 100) begin
                n++;
                @(negedge clk);
            end
            checkOutput("wait_d1", 32'(an), 32'hD);
        end
        @(negedge clk);
        applyStimulus(BASE, 32'hFFFF);
        waitDrain("drain_rewrite", 200);

        // Leading-zero blank with dp on digit 0: only digit 0 ever lights
        len_chk = 1'b0;
        applyStimulus(BASE + 1, 32'h0);
        applyStimulus(BASE, 32'h0005);
        for (int r = 0; r < 3; r++) begin
            disp_q.push_back(showOf(0, 4'h5, 1'b1));
        end
        applyStimulus(BASE + 1, 32'h0103);
        waitShowStart("lz_delay", 3);
        busRead("ctrl_lz_rb", BASE + 1, 32'h0103);
        waitDrain("drain_lz", 400);

        // Asynchronous reset in the middle of a show
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_an", 32'(an), 32'hF);
        checkOutput("async_seg", 32'(seg), 32'hFF);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        busRead("post_rst_value", BASE, 32'h0);
        busRead("post_rst_ctrl", BASE + 1, 32'h0);
        repeat (20) @(negedge clk);
        checkOutput("idle_an", 32'(an), 32'hF);

        // Unmapped address: writes ignored, reads return zero
        applyStimulus(BASE, 32'hA5A5);
        busRead("value_a5", BASE, 32'hA5A5);
        @(negedge clk);
        checkOutput("dout_hold", d_out, 32'hA5A5);
        applyStimulus(BASE + 5, 32'hDEADBEEF);
        busRead("unmapped_rd", BASE + 5, 32'h0);
        busRead("value_kept", BASE, 32'hA5A5);
        busRead("ctrl_kept", BASE + 1, 32'h0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
